// File: rtl/dffnrsnq_checker_if.sv
// Mismatch event port of dffnrsnq_checker: a one-entry record of the expected Q
// and the timestamp of the compare that failed.
interface dffnrsnq_checker_if #(
  parameter int TS_W = 16
);
  // valid/ready: a record transfers on a rising clk edge with evt_valid && evt_ready.
  // While evt_valid && !evt_ready, evt_exp and evt_ts hold and evt_valid stays high.
  logic            evt_valid;
  logic            evt_ready;
  logic            evt_exp;
  logic [TS_W-1:0] evt_ts;

  modport master (
    output evt_valid,
    output evt_exp,
    output evt_ts,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_exp,
    input  evt_ts,
    output evt_ready
  );
endinterface

// File: rtl/dffnrsnq_checker.sv
// Conformance checker for the negative-edge async-reset/async-set flop family:
// synchronises the cell pins, models the expected Q and reports late Q mismatches.
module dffnrsnq_checker #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 3,
  parameter int CNT_W       = 16,
  parameter int TS_W        = 16
) (
  input  logic               clk,
  input  logic               rn,
  input  logic               s_clkn,
  input  logic               s_d,
  input  logic               s_setn,
  input  logic               s_rn,
  input  logic               s_q,
  input  logic               en,
  input  logic               clr,
  output logic               exp_q,
  output logic               err,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  dffnrsnq_checker_if.master evt,
  output logic [1:0]         dbg_state,
  output logic               dbg_known
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_V = CW'(SETTLE);
  localparam logic [CW-1:0] ONE_V    = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sy_c, sy_d, sy_s, sy_r, sy_q;
  logic c, d, s, r, q;
  logic c1, d1, s1, r1;

  // Reset values mirror the cell's idle pin levels so reset itself is not an event.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      sy_c <= '1;
      sy_s <= '1;
      sy_r <= '1;
      sy_d <= '0;
      sy_q <= '0;
      c1   <= 1'b1;
      s1   <= 1'b1;
      r1   <= 1'b1;
      d1   <= 1'b0;
    end else begin
      sy_c <= {sy_c[SYNC_STAGES-2:0], s_clkn};
      sy_d <= {sy_d[SYNC_STAGES-2:0], s_d};
      sy_s <= {sy_s[SYNC_STAGES-2:0], s_setn};
      sy_r <= {sy_r[SYNC_STAGES-2:0], s_rn};
      sy_q <= {sy_q[SYNC_STAGES-2:0], s_q};
      c1   <= c;
      d1   <= d;
      s1   <= s;
      r1   <= r;
    end
  end

  assign c = sy_c[SYNC_STAGES-1];
  assign d = sy_d[SYNC_STAGES-1];
  assign s = sy_s[SYNC_STAGES-1];
  assign r = sy_r[SYNC_STAGES-1];
  assign q = sy_q[SYNC_STAGES-1];

  logic fall, evt_hit, load, load_val;
  logic exp_r, known;

  always_comb begin
    fall     = c1 & ~c;
    evt_hit  = fall | (r ^ r1) | (s ^ s1);
    load     = 1'b1;
    load_val = 1'b0;
    if (!r) begin
      load_val = 1'b0;
    end else if (!s) begin
      load_val = 1'b1;
    end else if (fall) begin
      load_val = d1;
    end else begin
      load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      exp_r <= 1'b0;
      known <= 1'b0;
    end else if (load) begin
      exp_r <= load_val;
      known <= 1'b1;
    end
  end

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          do_check;

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    do_check = 1'b0;
    case (state)
      ST_IDLE: begin
        if (evt_hit) begin
          state_nx = ST_WAIT;
          cnt_nx   = SETTLE_V;
        end
      end
      ST_WAIT: begin
        if (evt_hit) begin
          cnt_nx = SETTLE_V;
        end else if (cnt <= ONE_V) begin
          state_nx = ST_CHECK;
        end else begin
          cnt_nx = cnt - ONE_V;
        end
      end
      ST_CHECK: begin
        do_check = 1'b1;
        if (evt_hit) begin
          state_nx = ST_WAIT;
          cnt_nx   = SETTLE_V;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (!en) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end
  end

  logic [TS_W-1:0] ts;
  logic            vld, rec_exp;
  logic [TS_W-1:0] rec_ts;
  logic            mism, pop;

  assign mism = do_check & en & known & (q != exp_r);
  assign pop  = vld & evt.evt_ready;

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
    end
  end

  // A mismatch may refill the slot in the same cycle it is being drained.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      err          <= 1'b0;
      mismatch_cnt <= '0;
      drop_cnt     <= '0;
      vld          <= 1'b0;
      rec_exp      <= 1'b0;
      rec_ts       <= '0;
    end else if (clr) begin
      err          <= 1'b0;
      mismatch_cnt <= '0;
      drop_cnt     <= '0;
      vld          <= 1'b0;
    end else if (mism) begin
      err <= 1'b1;
      if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
      if (!vld || pop) begin
        vld     <= 1'b1;
        rec_exp <= exp_r;
        rec_ts  <= ts;
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end else if (pop) begin
      vld <= 1'b0;
    end
  end

  assign exp_q         = exp_r;
  assign evt.evt_valid = vld;
  assign evt.evt_exp   = rec_exp;
  assign evt.evt_ts    = rec_ts;
  assign dbg_state     = state;
  assign dbg_known     = known;

endmodule

// File: tb/tb_dffnrsnq_checker.sv
// Bench for dffnrsnq_checker: directed scenarios plus randomized pin sequences
// checked against a behavioural model of the flop cell and the event buffer.
`timescale 1ns/1ps
module tb_dffnrsnq_checker;
  localparam int SYNC_STAGES = 2;
  localparam int SETTLE      = 3;
  localparam int CNT_W       = 2;
  localparam int TS_W        = 8;
  localparam int VIS         = SYNC_STAGES + SETTLE + 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rn = 1'b0;
  logic s_clkn = 1'b1, s_d = 1'b0, s_setn = 1'b1, s_rn = 1'b1, s_q = 1'b0;
  logic en = 1'b1, clr = 1'b0;
  logic exp_q, err, dbg_known;
  logic [CNT_W-1:0] mismatch_cnt, drop_cnt;
  logic [1:0] dbg_state;

  dffnrsnq_checker_if #(.TS_W(TS_W)) evt_if ();

  dffnrsnq_checker #(
    .SYNC_STAGES(SYNC_STAGES), .SETTLE(SETTLE), .CNT_W(CNT_W), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rn(rn),
    .s_clkn(s_clkn), .s_d(s_d), .s_setn(s_setn), .s_rn(s_rn), .s_q(s_q),
    .en(en), .clr(clr),
    .exp_q(exp_q), .err(err), .mismatch_cnt(mismatch_cnt), .drop_cnt(drop_cnt),
    .evt(evt_if),
    .dbg_state(dbg_state), .dbg_known(dbg_known)
  );

  // clock/reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) if (rn) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // cell model: last applied pin levels and the flop state they imply
  logic m_clkn = 1'b1, m_d = 1'b0, m_setn = 1'b1, m_rn = 1'b1;
  logic m_exp = 1'b0, m_known = 1'b0;
  logic last_mism;

  // scoreboard for the event port and counters
  logic            m_err;
  int              m_mcnt, m_drop;
  logic            m_valid, m_rec_exp;
  logic [TS_W-1:0] m_rec_ts;
  logic [TS_W-1:0] exp_q_ts[$];

  function automatic logic cell_next(input logic a_clkn, input logic a_setn, input logic a_rn);
    if (!a_rn) return 1'b0;
    if (!a_setn) return 1'b1;
    if (m_clkn && !a_clkn) return m_d;
    return m_exp;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  // Drive one new set of cell pins; the cell sees D as it was before this step.
  task automatic apply_op(input logic a_clkn, input logic a_d, input logic a_setn,
                          input logic a_rn, input logic a_q, output int p);
    logic ev, nx;
    @(negedge clk);
    p  = cyc;
    ev = (m_clkn && !a_clkn) || (a_rn != m_rn) || (a_setn != m_setn);
    nx = cell_next(a_clkn, a_setn, a_rn);
    if (!a_rn || !a_setn || (m_clkn && !a_clkn)) m_known = 1'b1;
    m_exp     = nx;
    last_mism = ev && en && m_known && (a_q != nx);
    m_clkn = a_clkn; m_d = a_d; m_setn = a_setn; m_rn = a_rn;
    s_clkn = a_clkn; s_d = a_d; s_setn = a_setn; s_rn = a_rn; s_q = a_q;
  endtask

  task automatic test_reset();
    rn = 1'b0;
    evt_if.evt_ready = 1'b0;
    idle(3);
    n_cmp++; if (exp_q !== 1'b0) begin n_bad++; $display("FAIL reset_exp_q got=%0b want=0", exp_q); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%0b want=0", err); end
    n_cmp++; if (mismatch_cnt !== '0) begin n_bad++; $display("FAIL reset_mcnt got=%0d want=0", mismatch_cnt); end
    n_cmp++; if (drop_cnt !== '0) begin n_bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b want=0", evt_if.evt_valid); end
    n_cmp++; if (evt_if.evt_exp !== 1'b0) begin n_bad++; $display("FAIL reset_evt_exp got=%0b want=0", evt_if.evt_exp); end
    n_cmp++; if (evt_if.evt_ts !== '0) begin n_bad++; $display("FAIL reset_evt_ts got=%0d want=0", evt_if.evt_ts); end
    n_cmp++; if (dbg_known !== 1'b0) begin n_bad++; $display("FAIL reset_known got=%0b want=0", dbg_known); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    rn = 1'b1;
    idle(12);
    n_cmp++; if (dbg_known !== 1'b0) begin n_bad++; $display("FAIL idle_known got=%0b want=0", dbg_known); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL idle_err got=%0b want=0", err); end
  endtask

  task automatic test_first_load();
    int p;
    apply_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, p);
    idle(12);
    n_cmp++; if (exp_q !== 1'b0) begin n_bad++; $display("FAIL first_exp_q got=%0b want=0", exp_q); end
    n_cmp++; if (dbg_known !== 1'b1) begin n_bad++; $display("FAIL first_known got=%0b want=1", dbg_known); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL first_err got=%0b want=0", err); end
  endtask

  task automatic test_reset_dominance();
    int p;
    apply_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, p);
    idle(12);
    apply_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, p);
    idle(VIS);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL dom_err got=%0b want=1", err); end
    n_cmp++; if (mismatch_cnt !== CNT_W'(1)) begin n_bad++; $display("FAIL dom_mcnt got=%0d want=1", mismatch_cnt); end
    n_cmp++; if (evt_if.evt_valid !== 1'b1) begin n_bad++; $display("FAIL dom_valid got=%0b want=1", evt_if.evt_valid); end
    n_cmp++; if (evt_if.evt_exp !== 1'b0) begin n_bad++; $display("FAIL dom_evt_exp got=%0b want=0", evt_if.evt_exp); end
    n_cmp++; if (evt_if.evt_ts !== TS_W'(p + VIS - 1)) begin n_bad++; $display("FAIL dom_evt_ts got=%0d want=%0d", evt_if.evt_ts, TS_W'(p + VIS - 1)); end
    idle(5);
  endtask

  task automatic test_edge();
    int p;
    apply_op(1'b1, 1'b1, 1'b1, 1'b1, cell_next(1'b1, 1'b1, 1'b1), p);
    idle(12);
    pulse_clr();
    apply_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, p);
    @(negedge clk); s_q = 1'b1;
    idle(12);
    n_cmp++; if (exp_q !== 1'b1) begin n_bad++; $display("FAIL edge_exp_q got=%0b want=1", exp_q); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL edge_follow_err got=%0b want=0", err); end
    apply_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, p);
    idle(12);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL edge_q_only_err got=%0b want=0", err); end
    apply_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, p);
    idle(VIS - 1);
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL edge_early_valid got=%0b want=0", evt_if.evt_valid); end
    idle(1);
    n_cmp++; if (evt_if.evt_valid !== 1'b1) begin n_bad++; $display("FAIL edge_valid got=%0b want=1", evt_if.evt_valid); end
    n_cmp++; if (evt_if.evt_exp !== 1'b1) begin n_bad++; $display("FAIL edge_evt_exp got=%0b want=1", evt_if.evt_exp); end
    n_cmp++; if (evt_if.evt_ts !== TS_W'(p + VIS - 1)) begin n_bad++; $display("FAIL edge_evt_ts got=%0d want=%0d", evt_if.evt_ts, TS_W'(p + VIS - 1)); end
  endtask

  task automatic test_drop();
    int p, p1;
    pulse_clr();
    evt_if.evt_ready = 1'b0;
    apply_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, p);
    idle(12);
    for (int i = 0; i < 3; i++) begin
      apply_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, p);
      if (i == 0) p1 = p;
      idle(12);
      apply_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, p);
      idle(12);
    end
    n_cmp++; if (mismatch_cnt !== CNT_W'(3)) begin n_bad++; $display("FAIL drop_mcnt got=%0d want=3", mismatch_cnt); end
    n_cmp++; if (drop_cnt !== CNT_W'(2)) begin n_bad++; $display("FAIL drop_cnt got=%0d want=2", drop_cnt); end
    n_cmp++; if (evt_if.evt_ts !== TS_W'(p1 + VIS - 1)) begin n_bad++; $display("FAIL drop_keep_ts got=%0d want=%0d", evt_if.evt_ts, TS_W'(p1 + VIS - 1)); end
    apply_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, p);
    idle(VIS - 1);
    evt_if.evt_ready = 1'b1;
    idle(1);
    evt_if.evt_ready = 1'b0;
    n_cmp++; if (drop_cnt !== CNT_W'(2)) begin n_bad++; $display("FAIL popmis_drop got=%0d want=2", drop_cnt); end
    n_cmp++; if (mismatch_cnt !== CNT_W'(CNT_MAX)) begin n_bad++; $display("FAIL popmis_mcnt got=%0d want=%0d", mismatch_cnt, CNT_MAX); end
    n_cmp++; if (evt_if.evt_valid !== 1'b1) begin n_bad++; $display("FAIL popmis_valid got=%0b want=1", evt_if.evt_valid); end
    n_cmp++; if (evt_if.evt_ts !== TS_W'(p + VIS - 1)) begin n_bad++; $display("FAIL popmis_ts got=%0d want=%0d", evt_if.evt_ts, TS_W'(p + VIS - 1)); end
    for (int i = 0; i < 2; i++) begin
      apply_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, p);
      idle(12);
      apply_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, p);
      idle(12);
    end
    n_cmp++; if (mismatch_cnt !== CNT_W'(CNT_MAX)) begin n_bad++; $display("FAIL sat_mcnt got=%0d want=%0d", mismatch_cnt, CNT_MAX); end
    n_cmp++; if (drop_cnt !== CNT_W'(CNT_MAX)) begin n_bad++; $display("FAIL sat_drop got=%0d want=%0d", drop_cnt, CNT_MAX); end
  endtask

  task automatic test_clr_concurrent();
    int p;
    apply_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, p);
    idle(12);
    apply_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, p);
    idle(VIS - 1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clr_err got=%0b want=0", err); end
    n_cmp++; if (mismatch_cnt !== '0) begin n_bad++; $display("FAIL clr_mcnt got=%0d want=0", mismatch_cnt); end
    n_cmp++; if (drop_cnt !== '0) begin n_bad++; $display("FAIL clr_drop got=%0d want=0", drop_cnt); end
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid got=%0b want=0", evt_if.evt_valid); end
    idle(12);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clr_late_err got=%0b want=0", err); end
  endtask

  task automatic test_back_to_back();
    int p;
    apply_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, p);
    idle(12);
    pulse_clr();
    apply_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, p);
    idle(1);
    apply_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, p);
    idle(1);
    apply_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, p);
    idle(VIS - 1);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_early_err got=%0b want=0", err); end
    idle(1);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL b2b_err got=%0b want=1", err); end
    idle(12);
    n_cmp++; if (mismatch_cnt !== CNT_W'(1)) begin n_bad++; $display("FAIL b2b_mcnt got=%0d want=1", mismatch_cnt); end
  endtask

  task automatic test_ts_wrap();
    int p, n;
    pulse_clr();
    evt_if.evt_ready = 1'b0;
    apply_op(1'b1, 1'b1, 1'b1, 1'b1, cell_next(1'b1, 1'b1, 1'b1), p);
    idle(12);
    n = 0;
    while (TS_W'(cyc + VIS) != {TS_W{1'b1}} && n < 600) begin
      @(negedge clk);
      n++;
    end
    apply_op(1'b0, 1'b1, 1'b1, 1'b1, ~cell_next(1'b0, 1'b1, 1'b1), p);
    idle(12);
    n_cmp++; if (evt_if.evt_ts !== {TS_W{1'b1}}) begin n_bad++; $display("FAIL wrap_top_ts got=%0d want=%0d", evt_if.evt_ts, {TS_W{1'b1}}); end
    evt_if.evt_ready = 1'b1;
    idle(1);
    evt_if.evt_ready = 1'b0;
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_pop_valid got=%0b want=0", evt_if.evt_valid); end
    apply_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, p);
    idle(12);
    apply_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, p);
    exp_q_ts.push_back(TS_W'(p + VIS - 1));
    idle(12);
    n_cmp++; if (evt_if.evt_ts !== exp_q_ts[0]) begin n_bad++; $display("FAIL wrap_low_ts got=%0d want=%0d", evt_if.evt_ts, exp_q_ts[0]); end
    exp_q_ts.delete();
  endtask

  task automatic test_random();
    int p;
    logic a_clkn, a_d, a_setn, a_rn, a_q, rdy, do_clr;
    pulse_clr();
    m_err = 1'b0; m_mcnt = 0; m_drop = 0; m_valid = 1'b0;
    m_rec_exp = 1'b0; m_rec_ts = '0;
    for (int i = 0; i < 40; i++) begin
      a_clkn = 1'($urandom_range(0, 1));
      a_d    = 1'($urandom_range(0, 1));
      a_setn = ($urandom_range(0, 4) != 0);
      a_rn   = ($urandom_range(0, 4) != 0);
      a_q    = ($urandom_range(0, 9) < 7) ? cell_next(a_clkn, a_setn, a_rn) : 1'($urandom_range(0, 1));
      rdy    = ($urandom_range(0, 2) == 0);
      do_clr = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 6) != 0);
      evt_if.evt_ready = rdy;
      clr = do_clr;
      if (rdy && m_valid) m_valid = 1'b0;
      if (do_clr) begin m_err = 1'b0; m_mcnt = 0; m_drop = 0; m_valid = 1'b0; end
      apply_op(a_clkn, a_d, a_setn, a_rn, a_q, p);
      clr = 1'b0;
      if (last_mism) begin
        m_err = 1'b1;
        if (m_mcnt < CNT_MAX) m_mcnt++;
        if (!m_valid) begin
          m_valid = 1'b1; m_rec_exp = m_exp; m_rec_ts = TS_W'(p + VIS - 1);
        end else if (m_drop < CNT_MAX) begin
          m_drop++;
        end
        if (rdy) m_valid = 1'b0;
      end
      idle(12);
      n_cmp++; if (exp_q !== m_exp) begin n_bad++; $display("FAIL rnd%0d_exp_q got=%0b want=%0b", i, exp_q, m_exp); end
      n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL rnd%0d_err got=%0b want=%0b", i, err, m_err); end
      n_cmp++; if (mismatch_cnt !== CNT_W'(m_mcnt)) begin n_bad++; $display("FAIL rnd%0d_mcnt got=%0d want=%0d", i, mismatch_cnt, m_mcnt); end
      n_cmp++; if (drop_cnt !== CNT_W'(m_drop)) begin n_bad++; $display("FAIL rnd%0d_drop got=%0d want=%0d", i, drop_cnt, m_drop); end
      n_cmp++; if (evt_if.evt_valid !== m_valid) begin n_bad++; $display("FAIL rnd%0d_valid got=%0b want=%0b", i, evt_if.evt_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (evt_if.evt_exp !== m_rec_exp) begin n_bad++; $display("FAIL rnd%0d_evt_exp got=%0b want=%0b", i, evt_if.evt_exp, m_rec_exp); end
        n_cmp++; if (evt_if.evt_ts !== m_rec_ts) begin n_bad++; $display("FAIL rnd%0d_evt_ts got=%0d want=%0d", i, evt_if.evt_ts, m_rec_ts); end
      end
    end
    en = 1'b1;
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;
    test_reset();
    test_first_load();
    test_reset_dominance();
    test_edge();
    test_drop();
    test_clr_concurrent();
    test_back_to_back();
    test_ts_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
